mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester controller that shares the single-ported words_memory (word RAM with read/write strobes, captured on the clk rising edge) between the instruction-fetch port and the data (load/store) port of the CPU.
- Arbitrates pending requests and sequences each access through a fixed issue/wait/capture schedule.
- Returns read data and a one-cycle ack to the winning requester.
- Sits between the fetch/mem stages and the words_memory instance.

Parameters:
- MEM_LATENCY, 1: number of consecutive cycles the read/write strobe is held (1..15).
- DATA_PRIORITY, 1: 1 = data port always wins ties; 0 = round-robin on ties.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_req  input  1  instruction fetch request (read only).
- i_addr  input  32  fetch byte address.
- i_rdata  output  32  fetched word, registered.
- i_ack  output  1  fetch completion pulse.
- d_req  input  1  data request.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  32  data byte address.
- d_wdata  input  32  store data.
- d_rdata  output  32  load data, registered.
- d_ack  output  1  data completion pulse.
- mem_read  output  1  to words_memory read.
- mem_write  output  1  to words_memory write.
- mem_addr  output  32  to words_memory address.
- mem_wdata  output  32  to words_memory dataIn.
- mem_rdata  input  32  from words_memory dataOut.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - State IDLE; latency counter 0; last_grant = DATA, so the instruction port wins the first round-robin tie.
  - An in-flight access is abandoned: strobes drop immediately and no ack is issued.
- Requester rule:
  - Hold req, addr, we and wdata stable until ack.
  - Deassert req or present a new request in the cycle after ack.
  - A port's req is ignored in the cycle its own ack is high.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - If any unmasked req is pending, pick the winner.
    - Only one pending: that port wins.
    - Both pending, DATA_PRIORITY=1: data wins.
    - Both pending, DATA_PRIORITY=0: the port opposite last_grant wins.
  - Register mem_addr, mem_wdata (data port only), operation and grant; update last_grant; load counter with MEM_LATENCY-1; go to ISSUE.
- ISSUE:
  - Assert mem_read (fetch, or load with d_we=0) or mem_write (store d_we=1); never both.
  - Stay while counter≠0, decrementing each cycle; at 0 go to CAPTURE.
- CAPTURE:
  - Strobes low; mem_addr and mem_wdata hold.
  - At the exiting edge:
    - Read: load mem_rdata into the granted port's rdata register.
    - Write: leave d_rdata unchanged.
  - Set the granted port's ack for exactly one cycle; go to IDLE.
- Latency:
  - Request first seen in IDLE cycle 0 → ack high in cycle MEM_LATENCY+2 (3 for default).
  - rdata is valid in the ack cycle and held until that port's next read ack.
- Back-to-back:
  - The other port may be granted in the ack cycle (IDLE).
  - The same port's next request is granted in the cycle after its ack at the earliest.
  - Throughput: one access per MEM_LATENCY+2 cycles.
- Requests arriving during ISSUE/CAPTURE wait; no preemption or queueing beyond the held req.
- i_ack and d_ack are never high together.
- Addresses pass through unmodified; words_memory handles address mapping.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, CAPTURE=2'd2);
  - GRANT_I=1'b0, GRANT_D=1'b1;
  - counter width constant LAT_W=4.
- One sub-module, mem_arb_pick2:
  - combinational 2-way tie-breaker;
  - inputs i_req, d_req, last_grant, DATA_PRIORITY;
  - outputs grant and grant_valid.
- FSM, counter and data registers live in mem_port_arbiter.

Test Plan:
- Reset with d_req=1, then release → no strobe before the first IDLE cycle; all outputs 0 while rst_n=0.
- Store: d_req=1, d_we=1, d_addr=400, d_wdata=32'hF00FF176 → mem_write=1 with mem_addr=400 for 1 cycle; d_ack in cycle 3; d_rdata unchanged.
- Follow-up load: d_addr=400, d_we=0 → d_ack in cycle 3 with d_rdata=32'hF00FF176.
- Simultaneous i_req (addr 0) and d_req (load, addr 400), DATA_PRIORITY=1 → data acked first (cycle 3); fetch granted in the d_ack cycle, i_ack in cycle 6.
- DATA_PRIORITY=0, both held continuously → grants alternate I, D, I, D starting with I; no port served twice in a row.
- MEM_LATENCY=3, load in progress, rst_n pulsed low during ISSUE → strobes drop asynchronously; no d_ack; next request completes normally in 5 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   state_e : arbiter FSM encoding
//   GRANT_I / GRANT_D : grant encoding (fetch port / data port)
//   LAT_W   : width of the strobe-latency down-counter
package mem_arb_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick2.sv
// Combinational two-way tie-breaker between the fetch and data ports.
//   i_req_i       : fetch request (already masked by the caller)
//   d_req_i       : data request (already masked by the caller)
//   last_grant_i  : port granted most recently
//   grant_o       : winning port (GRANT_I / GRANT_D)
//   grant_valid_o : at least one request pending
module mem_arb_pick2
    import mem_arb_pkg::*;
#(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic last_grant_i,
    output logic grant_o,
    output logic grant_valid_o
);

    always_comb begin
        grant_valid_o = i_req_i | d_req_i;
        grant_o       = GRANT_I;
        if (i_req_i && d_req_i) begin
            grant_o = DATA_PRIORITY ? GRANT_D : ~last_grant_i;
        end else if (d_req_i) begin
            grant_o = GRANT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between the CPU fetch port and the
// load/store port. Each access runs IDLE -> ISSUE (strobe held MEM_LATENCY
// cycles) -> CAPTURE, and the winner receives a one-cycle ack together with
// its registered read data in the following IDLE cycle.
//
// Ports:
//   clk, rst_n                        : clock, async active-low reset
//   i_req, i_addr, i_rdata, i_ack     : fetch port (read only)
//   d_req, d_we, d_addr, d_wdata,
//   d_rdata, d_ack                    : data port
//   mem_read, mem_write, mem_addr,
//   mem_wdata, mem_rdata              : words_memory interface
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; pick winner, latch address/data
// ISSUE   | strobe asserted; counter counts down to 0
// CAPTURE | strobe low; latch mem_rdata on reads, raise ack at exit
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY   = 1,
    parameter int DATA_PRIORITY = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,

    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic               we_q, we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [31:0]        i_rdata_q, i_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic               i_ack_q, i_ack_d;
    logic               d_ack_q, d_ack_d;

    logic               pick;
    logic               pick_valid;

    // A port's request is still high during its own ack cycle; ignore it
    // there so the same access is not granted twice.
    mem_arb_pick2 #(
        .DATA_PRIORITY (DATA_PRIORITY != 0)
    ) u_pick (
        .i_req_i       (i_req & ~i_ack_q),
        .d_req_i       (d_req & ~d_ack_q),
        .last_grant_i  (last_grant_q),
        .grant_o       (pick),
        .grant_valid_o (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    cnt_d        = LAT_LOAD;
                    state_d      = ISSUE;
                    if (pick == GRANT_D) begin
                        we_d        = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        we_d        = 1'b0;
                        mem_addr_d  = i_addr;
                    end
                end
            end
            ISSUE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!we_q) begin
                    if (grant_q == GRANT_D) d_rdata_d = mem_rdata;
                    else                    i_rdata_d = mem_rdata;
                end
                if (grant_q == GRANT_D) d_ack_d = 1'b1;
                else                    i_ack_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= GRANT_I;
            last_grant_q <= GRANT_D;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
        end
    end

    // Strobes decode straight from the state register so an async reset
    // drops them immediately.
    assign mem_read  = (state_q == ISSUE) && !we_q;
    assign mem_write = (state_q == ISSUE) &&  we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (lat1/data-priority,
// lat1/round-robin, lat3/data-priority), each with its own word memory.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    logic mem_clr;

    logic [2:0]  i_req, d_req, d_we;
    logic [31:0] i_addr [3];
    logic [31:0] d_addr [3];
    logic [31:0] d_wdata [3];
    logic [31:0] i_rdata [3];
    logic [31:0] d_rdata [3];
    logic [2:0]  i_ack, d_ack, mem_read, mem_write;
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];

    int n_tests;
    int n_fail;

    typedef struct {
        int          dut;
        bit          port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 3 : 1;
        localparam int DP  = (g == 1) ? 0 : 1;

        mem_port_arbiter #(
            .MEM_LATENCY   (LAT),
            .DATA_PRIORITY (DP)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_req     (i_req[g]),
            .i_addr    (i_addr[g]),
            .i_rdata   (i_rdata[g]),
            .i_ack     (i_ack[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_rdata   (d_rdata[g]),
            .d_ack     (d_ack[g]),
            .mem_read  (mem_read[g]),
            .mem_write (mem_write[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );

        // Word memory preset so that word at byte address A holds 32'hA5000000|A.
        logic [31:0] mem [256];
        logic [31:0] rd;
        always @(posedge clk) begin
            if (mem_clr) begin
                for (int j = 0; j < 256; j++) mem[j] <= 32'hA500_0000 | 32'(j << 2);
                rd <= '0;
            end else begin
                if (mem_write[g]) mem[mem_addr[g][9:2]] <= mem_wdata[g];
                if (mem_read[g])  rd <= mem[mem_addr[g][9:2]];
            end
        end
        assign mem_rdata[g] = rd;
    end

    function automatic int lat_of(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every ack pops the scoreboard and is compared against it.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_read[k] || mem_write[k])
                check("strobe_exclusive", {31'd0, mem_read[k] & mem_write[k]}, 32'd0);
            if (i_ack[k] || d_ack[k]) begin
                check("ack_exclusive", {31'd0, i_ack[k] & d_ack[k]}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_dut", 32'(k), 32'(e.dut));
                    check("ack_port", {31'd0, d_ack[k]}, {31'd0, e.port});
                    check("ack_rdata", d_ack[k] ? d_rdata[k] : i_rdata[k], e.data);
                end
            end
        end
    end

    // Single access; cycle 0 is the IDLE cycle in which the request is first
    // seen. With rel set, reset is held through the drive edge and released
    // inside cycle 0.
    task automatic do_single(input int k, input bit port, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp, input bit rel);
        int  l;
        bit  store;
        l = lat_of(k);
        store = port & we;
        @(posedge clk); #1;
        if (port) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
        end else begin
            i_req[k] = 1'b1; i_addr[k] = addr;
        end
        sb.push_back('{dut: k, port: port, data: exp});
        if (rel) begin
            for (int j = 0; j < 3; j++) begin
                check("rst_acks_strobes", {28'd0, i_ack[j], d_ack[j], mem_read[j], mem_write[j]}, 32'd0);
                check("rst_i_rdata", i_rdata[j], 32'd0);
                check("rst_d_rdata", d_rdata[j], 32'd0);
                check("rst_mem_addr", mem_addr[j], 32'd0);
                check("rst_mem_wdata", mem_wdata[j], 32'd0);
            end
            #1 rst_n = 1'b1;
            #1;
        end
        for (int n = 0; n <= l + 2; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            check("cyc_mem_read",  {31'd0, mem_read[k]},  {31'd0, (n >= 1 && n <= l && !store)});
            check("cyc_mem_write", {31'd0, mem_write[k]}, {31'd0, (n >= 1 && n <= l && store)});
            check("cyc_ack", {31'd0, port ? d_ack[k] : i_ack[k]}, {31'd0, (n == l + 2)});
            if (n >= 1 && n <= l) begin
                check("issue_mem_addr", mem_addr[k], addr);
                if (store) check("issue_mem_wdata", mem_wdata[k], wdata);
            end
            if (n == l + 2) begin
                if (port) d_req[k] = 1'b0;
                else      i_req[k] = 1'b0;
            end
        end
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    initial begin : stim
        int dn, in_c, cnt;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        mem_clr = 1'b1;
        i_req = '0; d_req = '0; d_we = '0;
        for (int k = 0; k < 3; k++) begin
            i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;

        // Request present during reset, then release: first load of addr 8.
        do_single(0, 1'b1, 1'b0, 32'd8, 32'd0, 32'hA500_0008, 1'b1);
        // Store leaves d_rdata at the previous load value.
        do_single(0, 1'b1, 1'b1, 32'd400, 32'hF00F_F176, 32'hA500_0008, 1'b0);
        do_single(0, 1'b1, 1'b0, 32'd400, 32'd0, 32'hF00F_F176, 1'b0);
        // Fetch alone.
        do_single(0, 1'b0, 1'b0, 32'd12, 32'd0, 32'hA500_000C, 1'b0);

        // Tie with data priority: data at cycle 3, fetch at cycle 6.
        @(posedge clk); #1;
        i_req[0] = 1'b1; i_addr[0] = 32'd0;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'd400;
        sb.push_back('{dut: 0, port: 1'b1, data: 32'hF00F_F176});
        sb.push_back('{dut: 0, port: 1'b0, data: 32'hA500_0000});
        dn = -1; in_c = -1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (d_ack[0]) begin dn = n; d_req[0] = 1'b0; end
            if (i_ack[0]) begin in_c = n; i_req[0] = 1'b0; end
        end
        check("prio_d_ack_cycle", 32'(dn), 32'd3);
        check("prio_i_ack_cycle", 32'(in_c), 32'd6);

        // Round robin, both held: I, D, I, D at cycles 3, 6, 9, 12.
        @(posedge clk); #1;
        i_req[1] = 1'b1; i_addr[1] = 32'd8;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'd12;
        for (int j = 0; j < 4; j++)
            sb.push_back('{dut: 1, port: j[0], data: j[0] ? 32'hA500_000C : 32'hA500_0008});
        cnt = 0;
        for (int n = 1; n <= 30 && cnt < 4; n++) begin
            @(posedge clk); #1;
            if (i_ack[1] || d_ack[1]) begin
                check("rr_cycle", 32'(n), 32'(3 * (cnt + 1)));
                check("rr_port", {31'd0, d_ack[1]}, {31'd0, cnt[0]});
                cnt++;
                if (cnt == 4) begin
                    i_req[1] = 1'b0; d_req[1] = 1'b0;
                end
            end
        end
        check("rr_count", 32'(cnt), 32'd4);

        // Latency 3: reset pulsed during ISSUE abandons the load.
        @(posedge clk); #1;
        d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'd400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("lat3_issue_read", {31'd0, mem_read[2]}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("lat3_async_drop", {30'd0, mem_read[2], mem_write[2]}, 32'd0);
        d_req[2] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            check("abort_no_ack", {30'd0, i_ack[2], d_ack[2]}, 32'd0);
        end
        do_single(2, 1'b1, 1'b0, 32'd400, 32'd0, 32'hA500_0190, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
